// File: rtl/cpu_step_ctrl_pkg.sv
// Shared constants for the CPU step controller: state encoding and default sizing.
// Latency: n/a. Backpressure: n/a.
package cpu_step_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_EXEC = 2'b10;
    localparam logic [1:0] ST_HALT = 2'b11;

    localparam int DEF_DEB_CYCLES = 16;
    localparam int DEF_RUN_DIV    = 4;
    localparam int DEF_CNT_W      = 16;

    function automatic logic brk_hit(input logic of_en, input logic zf_en,
                                     input logic of_f,  input logic zf_f);
        return (of_en & of_f) | (zf_en & zf_f);
    endfunction

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// Board/CPU-facing bundle of the step controller; master = board and CPU side.
// Latency: n/a. Backpressure: none, level signals and a one-cycle enable.
interface cpu_step_ctrl_if
    import cpu_step_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             step_btn;
    logic             run_sw;
    logic             brk_of_en;
    logic             brk_zf_en;
    logic             ofa;
    logic             zfa;
    logic             cpu_ce;
    logic [CNT_W-1:0] step_cnt;
    logic             halted;
    logic [1:0]       state_o;

    modport master (
        output step_btn, run_sw, brk_of_en, brk_zf_en, ofa, zfa,
        input  cpu_ce, step_cnt, halted, state_o
    );

    modport slave (
        input  step_btn, run_sw, brk_of_en, brk_zf_en, ofa, zfa,
        output cpu_ce, step_cnt, halted, state_o
    );
endinterface

// File: rtl/cpu_step_ctrl_sync_debounce.sv
// 2-FF synchroniser followed by a stability-count debouncer with rising-edge pulse.
// Latency: 2 sync cycles + DEB_CYCLES stable samples. Backpressure: none.
module sync_debounce
    import cpu_step_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clka,
    input  logic rsta,
    input  logic din,
    output logic dout,
    output logic rise
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            dout <= 1'b0;
            rise <= 1'b0;
            cnt  <= '0;
        end else begin
            s1   <= din;
            s2   <= s1;
            rise <= 1'b0;
            // Any sample agreeing with the current output restarts the run.
            if (s2 == dout) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                dout <= s2;
                rise <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/cpu_step_ctrl.sv
// Execution controller: single-step or free-run issue of a one-cycle CPU enable, flag breakpoints.
// Latency: cpu_ce one cycle after the debounced step edge; free-run period RUN_DIV+2. Backpressure: none.
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int RUN_DIV    = DEF_RUN_DIV,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic          clka,
    input  logic          rsta,
    cpu_step_ctrl_if.slave bus
);
    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    logic             step_db;
    logic             step_rise;
    logic             run_db;
    logic             run_rise;
    logic             step_pulse;
    logic             run_lvl;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic             chk;
    logic             chk_nx;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nx;
    logic             ret_run;
    logic             ret_run_nx;
    logic             ce_q;
    logic [CNT_W-1:0] cnt_q;

    sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
        .clka (clka),
        .rsta (rsta),
        .din  (bus.step_btn),
        .dout (step_db),
        .rise (step_rise)
    );

    sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_deb (
        .clka (clka),
        .rsta (rsta),
        .din  (bus.run_sw),
        .dout (run_db),
        .rise (run_rise)
    );

    assign step_pulse = step_rise & step_db;
    assign run_lvl    = run_db | run_rise;

    // EXEC and its CHECK substate share one encoding; chk tells them apart.
    always_comb begin
        state_nx   = state;
        chk_nx     = 1'b0;
        div_nx     = div;
        ret_run_nx = ret_run;
        case (state)
            ST_IDLE: begin
                if (run_lvl) begin
                    state_nx = ST_RUN;
                    div_nx   = '0;
                end else if (step_pulse) begin
                    state_nx   = ST_EXEC;
                    ret_run_nx = 1'b0;
                end
            end
            ST_RUN: begin
                if (!run_lvl) begin
                    state_nx = ST_IDLE;
                end else if (div == DIV_W'(RUN_DIV - 1)) begin
                    state_nx   = ST_EXEC;
                    ret_run_nx = 1'b1;
                end else begin
                    div_nx = div + 1'b1;
                end
            end
            ST_EXEC: begin
                if (!chk) begin
                    chk_nx = 1'b1;
                end else if (brk_hit(bus.brk_of_en, bus.brk_zf_en, bus.ofa, bus.zfa)) begin
                    state_nx = ST_HALT;
                end else if (ret_run && run_lvl) begin
                    state_nx = ST_RUN;
                    div_nx   = '0;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                if (step_pulse) begin
                    state_nx = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            state   <= ST_IDLE;
            chk     <= 1'b0;
            div     <= '0;
            ret_run <= 1'b0;
            ce_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nx;
            chk     <= chk_nx;
            div     <= div_nx;
            ret_run <= ret_run_nx;
            ce_q    <= (state_nx == ST_EXEC) && !chk_nx;
            if (state == ST_EXEC && !chk) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.cpu_ce   = ce_q;
    assign bus.step_cnt = cnt_q;
    assign bus.halted   = (state == ST_HALT);
    assign bus.state_o  = state;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with a tiny CPU flag model.
module tb_cpu_step_ctrl;
    localparam int CNT_W = 4;

    logic clka;
    logic rsta;
    int   checks;
    int   errors;

    cpu_step_ctrl_if #(.CNT_W(CNT_W)) bus ();

    cpu_step_ctrl #(.DEB_CYCLES(4), .RUN_DIV(4), .CNT_W(CNT_W)) dut (
        .clka (clka),
        .rsta (rsta),
        .bus  (bus.slave)
    );

    initial begin
        clka = 1'b0;
        forever #5 clka = ~clka;
    end

    // CPU flag model: ofa rises once the 3rd instruction has executed.
    int icnt;
    always @(posedge clka or negedge rsta) begin
        if (!rsta) begin
            icnt    <= 0;
            bus.ofa <= 1'b0;
        end else if (bus.cpu_ce) begin
            icnt    <= icnt + 1;
            bus.ofa <= (icnt + 1 >= 3);
        end
    end

    // cpu_ce monitor, sampled on the falling edge.
    int cyc;
    int ce_total;
    int ce_maxw;
    int cur_w;
    int ce_times[$];
    always @(negedge clka) begin
        cyc = cyc + 1;
        if (bus.cpu_ce) begin
            if (cur_w == 0) begin
                ce_total = ce_total + 1;
                ce_times.push_back(cyc);
            end
            cur_w = cur_w + 1;
            if (cur_w > ce_maxw) ce_maxw = cur_w;
        end else begin
            cur_w = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rsta         = 1'b0;
        bus.step_btn = 1'b0;
        bus.run_sw   = 1'b0;
        repeat (3) @(negedge clka);
        ce_times.delete();
        ce_total = 0;
        ce_maxw  = 0;
        rsta     = 1'b1;
        repeat (2) @(negedge clka);
    endtask

    task automatic press(input int bounces);
        for (int i = 0; i < bounces; i++) begin
            bus.step_btn = 1'b1;
            @(negedge clka);
            bus.step_btn = 1'b0;
            @(negedge clka);
        end
        bus.step_btn = 1'b1;
        repeat (20) @(negedge clka);
        bus.step_btn = 1'b0;
        repeat (20) @(negedge clka);
    endtask

    initial begin
        int n;
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        cur_w         = 0;
        ce_total      = 0;
        ce_maxw       = 0;
        rsta          = 1'b0;
        bus.step_btn  = 1'b0;
        bus.run_sw    = 1'b0;
        bus.brk_of_en = 1'b0;
        bus.brk_zf_en = 1'b0;
        bus.zfa       = 1'b0;

        // Reset state and quiet idle.
        repeat (2) @(negedge clka);
        chk("rst_ce", bus.cpu_ce, 0);
        chk("rst_cnt", bus.step_cnt, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_state", bus.state_o, 0);
        rsta = 1'b1;
        repeat (10) @(negedge clka);
        chk("idle_no_ce", ce_total, 0);

        // Single step with bounce, then a clean press.
        press(3);
        chk("step1_ce", ce_total, 1);
        chk("step1_width", ce_maxw, 1);
        chk("step1_cnt", bus.step_cnt, 1);
        press(0);
        chk("step2_cnt", bus.step_cnt, 2);
        chk("step2_state", bus.state_o, 0);

        // Free run with breakpoints disabled.
        do_reset();
        bus.run_sw = 1'b1;
        repeat (60) @(negedge clka);
        bus.run_sw = 1'b0;
        chk("run_many", (ce_times.size() >= 6), 1);
        repeat (30) @(negedge clka);
        n = ce_total;
        repeat (20) @(negedge clka);
        chk("run_stopped", ce_total, n);
        chk("run_state_idle", bus.state_o, 0);
        chk("run_width", ce_maxw, 1);
        for (int i = 1; i < ce_times.size(); i++)
            chk("run_gap", ce_times[i] - ce_times[i-1], 6);

        // Overflow breakpoint after the 3rd instruction.
        do_reset();
        bus.brk_of_en = 1'b1;
        bus.run_sw    = 1'b1;
        for (int i = 0; i < 300 && !bus.halted; i++) @(negedge clka);
        chk("brk_halted", bus.halted, 1);
        chk("brk_state", bus.state_o, 3);
        chk("brk_cnt", bus.step_cnt, 3);
        bus.run_sw = 1'b0;
        repeat (30) @(negedge clka);
        chk("brk_no_more_ce", ce_total, 3);
        chk("brk_still_halted", bus.halted, 1);
        press(0);
        chk("brk_ack_halted", bus.halted, 0);
        chk("brk_ack_state", bus.state_o, 0);
        chk("brk_ack_no_issue", ce_total, 3);
        bus.brk_of_en = 1'b0;

        // Zero-flag breakpoint on a single step.
        do_reset();
        bus.brk_zf_en = 1'b1;
        bus.zfa       = 1'b1;
        press(0);
        chk("zf_halted", bus.halted, 1);
        chk("zf_cnt", bus.step_cnt, 1);
        press(0);
        chk("zf_ack_state", bus.state_o, 0);
        chk("zf_ack_cnt", bus.step_cnt, 1);
        bus.brk_zf_en = 1'b0;
        bus.zfa       = 1'b0;

        // Counter wrap at 2^CNT_W.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            press(0);
            if (i == 14) chk("wrap_15", bus.step_cnt, 15);
        end
        chk("wrap_0", bus.step_cnt, 0);
        chk("wrap_ce", ce_total, 16);

        // Asynchronous reset in the EXEC cycle.
        do_reset();
        bus.step_btn = 1'b1;
        for (int i = 0; i < 50 && !bus.cpu_ce; i++) @(negedge clka);
        chk("arst_ce_seen", bus.cpu_ce, 1);
        rsta = 1'b0;
        #1;
        chk("arst_ce", bus.cpu_ce, 0);
        chk("arst_cnt", bus.step_cnt, 0);
        chk("arst_state", bus.state_o, 0);
        bus.step_btn = 1'b0;
        repeat (2) @(negedge clka);
        rsta = 1'b1;
        repeat (2) @(negedge clka);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
- Execution controller for the R-I CPU datapath. Gates CPU progress through a one-cycle clock-enable, `cpu_ce`, in one of two modes:
  - single-step: one debounced button press executes exactly one instruction;
  - free-run: an instruction is issued every `RUN_DIV+2` cycles.
- Watches the CPU flags `ofa`/`zfa` after each instruction and halts on enabled flag breakpoints.
- Sits between board inputs (button, switch) and the CPU top. `step_cnt` feeds the LED display path.

Parameters:
- `DEB_CYCLES`, 16: consecutive stable synchronised samples required before a debounced input changes.
- `RUN_DIV`, 4: cycles spent in RUN before each issue. Legal range ≥1.
- `CNT_W`, 16: width of the executed-instruction counter.

Ports:
- `clka`, in, 1: sole clock, rising edge.
- `rsta`, in, 1: asynchronous active-low reset.
- `step_btn`, in, 1: raw step push-button, asynchronous and bouncy.
- `run_sw`, in, 1: raw run switch, asynchronous and bouncy. 1 = free-run.
- `brk_of_en`, in, 1: halt when `ofa`=1 after an instruction.
- `brk_zf_en`, in, 1: halt when `zfa`=1 after an instruction.
- `ofa`, in, 1: CPU overflow flag, registered in the CPU on `clka`.
- `zfa`, in, 1: CPU zero flag, registered in the CPU on `clka`.
- `cpu_ce`, out, 1: CPU clock enable. High for exactly one cycle per instruction.
- `step_cnt`, out, `CNT_W`: count of issued instructions.
- `halted`, out, 1: high while in HALT.
- `state_o`, out, 2: current FSM state encoding, for debug and LEDs.

Behaviour:
- Reset (`rsta`=0, async): state←IDLE. All outputs 0. Sync FFs, debounced values, divider and `ret_run` cleared. `cpu_ce` drops the instant `rsta` falls, including mid-EXEC. Reset release takes effect at the next `clka` edge.
- Input conditioning:
  - `step_btn` and `run_sw` each pass through a 2-FF synchroniser.
  - The debounced value changes only after `DEB_CYCLES` consecutive synchronised samples differ from it.
  - Any mismatch gap restarts the stability count.
  - `step_pulse` = one-cycle pulse on the debounced 0→1 edge of the step input.
- FSM states and encoding: IDLE=00, RUN=01, EXEC=10, HALT=11. CHECK is a one-cycle substate of EXEC and is reported as 10 on `state_o`.
- IDLE:
  - `cpu_ce`=0.
  - Debounced run=1 → RUN, divider←0. This has priority over `step_pulse`.
  - Else `step_pulse` → EXEC, `ret_run`←0.
- RUN:
  - Divider counts 0..`RUN_DIV`-1.
  - Debounced run=0 → IDLE, no issue.
  - Else divider=`RUN_DIV`-1 → EXEC, `ret_run`←1.
  - `step_pulse` is ignored.
- EXEC:
  - `cpu_ce`=1 for exactly this one cycle. `cpu_ce` is a registered output, high in the EXEC cycle only.
  - `step_cnt`←`step_cnt`+1, modulo 2^`CNT_W` (wrap, no saturation).
  - Then → CHECK.
- CHECK:
  - `cpu_ce`=0. Flags now reflect the just-executed instruction.
  - hit = (`brk_of_en`&`ofa`) | (`brk_zf_en`&`zfa`).
  - hit → HALT.
  - Else `ret_run`&debounced run → RUN, divider←0.
  - Else → IDLE.
- HALT:
  - `cpu_ce`=0, `halted`=1.
  - `step_pulse` → IDLE. This acknowledges the halt; no instruction is issued.
  - If run is still high, IDLE→RUN on the following cycle. A persistent flag therefore re-halts after one more instruction. This is intended.
- Free-run period is `RUN_DIV`+2 cycles per instruction.
- Boundary rules:
  - `step_pulse` arriving during EXEC, CHECK or RUN is dropped, not queued.
  - A run fall during EXEC/CHECK lets the instruction complete, then → IDLE.
  - Breakpoint enables are sampled only in CHECK.

Decomposition:
- Shared package/header holds:
  - state encoding constants `ST_IDLE`/`ST_RUN`/`ST_EXEC`/`ST_HALT`;
  - default `DEB_CYCLES`/`RUN_DIV`/`CNT_W`.
- Sub-module `sync_debounce` (params `DEB_CYCLES`; ports `clka`, `rsta`, `din`, `dout`, `rise`), instantiated twice: once for step, once for run.
- FSM, divider and counter live in `cpu_step_ctrl`.

Test Plan:
- Reset: hold `rsta`=0 → all outputs 0, `state_o`=00. Release, 10 idle cycles → `cpu_ce` never asserts.
- Single step (`DEB_CYCLES`=4):
  - Press `step_btn` with 3 bounce toggles, then hold 20 cycles → exactly one `cpu_ce` pulse, 1 cycle wide, `step_cnt`=1.
  - A second clean press → `step_cnt`=2.
- Free-run (`RUN_DIV`=4): `run_sw`=1 for 60 cycles → `cpu_ce` pulses exactly 6 cycles apart. `run_sw`→0 → pulses stop; `state_o` returns to 00.
- Breakpoint: `brk_of_en`=1, model raises `ofa` after the 3rd instruction in run → `halted`=1, `state_o`=11, `step_cnt`=3, no further `cpu_ce`. Step press → IDLE, `halted`=0.
- Wrap (`CNT_W`=4): 16 single steps → `step_cnt`=0 after the 16th.
- Async reset mid-EXEC: assert `rsta` while `cpu_ce`=1 → `cpu_ce`=0 before the next `clka` edge, and `step_cnt`=0.
